// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
package mult_div_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_ITERS = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MULT_WAIT,
    DIV_RUN,
    DIV_FIX
  } state_e;

  // Two's-complement magnitude; -2^31 maps to 0x80000000 read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request, multiplier and HI/LO result signals of the multiply/divide controller.
interface mult_div_ctrl_if;
  import mult_div_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic [WIDTH-1:0] mult_prod_lo;
  logic [WIDTH-1:0] mult_prod_hi;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mult_prod_lo, mult_prod_hi,
    input  mult_a, mult_b, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, mult_prod_lo, mult_prod_hi,
    output mult_a, mult_b, busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_ctrl_div_seq.sv
// Signed 32-iteration restoring divider: loads magnitudes, shifts out one
// quotient bit per edge, then presents sign-corrected quotient/remainder.
module div_seq
  import mult_div_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [5:0]       cnt_q;
  logic             active_q;
  logic             sign_a_q;
  logic             neg_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   dsr_q;
  logic [WIDTH:0]   trial;

  // Remainder stays below the divisor, so the shifted trial needs WIDTH+1 bits.
  assign trial = {rem_q, quo_q[WIDTH-1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
    end else if (start_i) begin
      cnt_q    <= 6'(DIV_ITERS);
      active_q <= 1'b1;
      sign_a_q <= a_i[WIDTH-1];
      neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      quo_q    <= mag(a_i);
      rem_q    <= '0;
      dsr_q    <= {1'b0, mag(b_i)};
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 6'd1;
        if (trial >= dsr_q) begin
          rem_q <= WIDTH'(trial - dsr_q);
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign last_o = active_q && (cnt_q == 6'd1);
  assign done_o = active_q && (cnt_q == 6'd0);
  assign quo_o  = neg_q    ? -quo_q : quo_q;
  assign rem_o  = sign_a_q ? -rem_q : rem_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// MULT/DIV sequencer feeding the external Booth multiplier and owning HI/LO.
// States: IDLE accept | MULT_WAIT product latency | DIV_RUN iterate | DIV_FIX write-back.
module mult_div_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 2
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  mult_div_pkg::state_e state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] mult_a_q;
  logic [WIDTH-1:0] mult_b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             div_start;
  logic             div_last;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign div_start = (state_q == mult_div_pkg::IDLE) && bus.start &&
                     (bus.op == mult_div_pkg::OP_DIV) && (bus.b != '0);

  div_seq u_div_seq (
    .clock   (clock),
    .reset   (reset),
    .start_i (div_start),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .last_o  (div_last),
    .done_o  (div_done),
    .quo_o   (div_quo),
    .rem_o   (div_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= mult_div_pkg::IDLE;
      cnt_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        mult_div_pkg::IDLE: begin
          if (bus.start) begin
            if (bus.op == mult_div_pkg::OP_DIV) begin
              if (bus.b == '0) begin
                done_q <= 1'b1;
                dz_q   <= 1'b1;
              end else begin
                state_q <= mult_div_pkg::DIV_RUN;
              end
            end else begin
              mult_a_q <= bus.a;
              mult_b_q <= bus.b;
              cnt_q    <= '0;
              state_q  <= mult_div_pkg::MULT_WAIT;
            end
          end
        end
        mult_div_pkg::MULT_WAIT: begin
          if (cnt_q == 4'(MULT_LAT - 1)) begin
            hi_q    <= bus.mult_prod_hi;
            lo_q    <= bus.mult_prod_lo;
            done_q  <= 1'b1;
            state_q <= mult_div_pkg::IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        mult_div_pkg::DIV_RUN: begin
          if (div_last) state_q <= mult_div_pkg::DIV_FIX;
        end
        mult_div_pkg::DIV_FIX: begin
          if (div_done) begin
            hi_q    <= div_rem;
            lo_q    <= div_quo;
            done_q  <= 1'b1;
            state_q <= mult_div_pkg::IDLE;
          end
        end
        default: state_q <= mult_div_pkg::IDLE;
      endcase
    end
  end

  assign bus.mult_a   = mult_a_q;
  assign bus.mult_b   = mult_b_q;
  assign bus.busy     = (state_q != mult_div_pkg::IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized and directed bench for mult_div_ctrl against an arithmetic reference model.
module tb_mult_div_ctrl;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  mult_div_ctrl_if bus ();

  mult_div_ctrl #(.WIDTH(32), .MULT_LAT(2)) dut (
    .clock (clock),
    .reset (rst),
    .bus   (bus)
  );

  // Stand-in for the external multiplier: one registered stage.
  longint mul_tmp;
  always @(posedge clock) begin
    mul_tmp = longint'($signed(bus.mult_a)) * longint'($signed(bus.mult_b));
    bus.mult_prod_hi <= mul_tmp[63:32];
    bus.mult_prod_lo <= mul_tmp[31:0];
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: an op completes a fixed number of edges after acceptance
  // with the result given by plain signed arithmetic.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_ma = 0, m_mb = 0, r_hi = 0, r_lo = 0;
  logic        m_done = 0, m_dz = 0;
  longint      sa, sb, mq, mr, mp;

  always @(posedge clock) begin
    if (rst) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_ma = 0; m_mb = 0; m_done = 0; m_dz = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_done = 1;
        end
      end else if (bus.start) begin
        if (bus.op == 1'b0) begin
          m_ma = bus.a; m_mb = bus.b;
          mp = longint'($signed(bus.a)) * longint'($signed(bus.b));
          r_hi = mp[63:32]; r_lo = mp[31:0];
          m_left = 2;
        end else if (bus.b == 32'd0) begin
          m_done = 1; m_dz = 1;
        end else begin
          sa = longint'($signed(bus.a));
          sb = longint'($signed(bus.b));
          mq = sa / sb;
          mr = sa % sb;
          r_lo = mq[31:0]; r_hi = mr[31:0];
          m_left = 33;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy",     64'(bus.busy),     64'(m_left > 0));
      chk("done",     64'(bus.done),     64'(m_done));
      chk("div_zero", 64'(bus.div_zero), 64'(m_dz));
      chk("hi",       64'(bus.hi),       64'(m_hi));
      chk("lo",       64'(bus.lo),       64'(m_lo));
      chk("mult_a",   64'(bus.mult_a),   64'(m_ma));
      chk("mult_b",   64'(bus.mult_b),   64'(m_mb));
    end
  end

  // Called a little after a falling edge. lat = edges from acceptance to
  // completion (-1 if no done within budget).
  task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input int inj_at, input int rst_at,
                       output int lat, output int nbusy, output logic dz);
    int k;
    bit got;
    #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clock);
    got = 0; k = 0; lat = -1; nbusy = 0; dz = 1'b0;
    while (!got && k < 60) begin
      @(negedge clock);
      k++;
      if (bus.done) begin
        got = 1; lat = k - 1; dz = bus.div_zero;
      end else if (bus.busy) begin
        nbusy++;
      end
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);
      end
      #1;
      if (k == inj_at) begin
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h1234_5678; bus.b = 32'h0BAD_F00D;
      end else begin
        bus.start = 1'b0; bus.op = 1'($urandom_range(0, 1)); bus.a = $urandom(); bus.b = $urandom();
      end
      rst = (k == rst_at);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom();
    endcase
  endfunction

  int          lat, nb, exp_lat;
  logic        dz, ro;
  logic [31:0] rx, ry;

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    @(posedge clock);
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hi",   64'(bus.hi),   64'd0);
    chk("reset_lo",   64'(bus.lo),   64'd0);
    chk("reset_ma",   64'(bus.mult_a), 64'd0);
    #1 rst = 1'b0;

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1, lat, nb, dz);
    chk("mult_lat",  64'(lat), 64'd2);
    chk("mult_busy", 64'(nb),  64'd2);
    chk("mult_hi",   64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo",   64'(bus.lo), 64'hFFFF_FFEB);

    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1, lat, nb, dz);
    chk("div1_lat", 64'(lat), 64'd33);
    chk("div1_lo",  64'(bus.lo), 64'hFFFF_FFFD);
    chk("div1_hi",  64'(bus.hi), 64'd1);
    chk("div1_dz",  64'(dz), 64'd0);

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, lat, nb, dz);
    chk("div2_lat", 64'(lat), 64'd33);
    chk("div2_lo",  64'(bus.lo), 64'hFFFF_FFFD);
    chk("div2_hi",  64'(bus.hi), 64'hFFFF_FFFF);

    do_op(1'b1, 32'd5, 32'd0, -1, -1, lat, nb, dz);
    chk("dz_lat",  64'(lat), 64'd0);
    chk("dz_flag", 64'(dz),  64'd1);
    chk("dz_busy", 64'(nb),  64'd0);
    chk("dz_lo",   64'(bus.lo), 64'hFFFF_FFFD);
    chk("dz_hi",   64'(bus.hi), 64'hFFFF_FFFF);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, lat, nb, dz);
    chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);
    chk("ovf_hi", 64'(bus.hi), 64'd0);

    do_op(1'b1, 32'h8000_0000, 32'd1, -1, -1, lat, nb, dz);
    chk("min1_lo", 64'(bus.lo), 64'h8000_0000);
    chk("min1_hi", 64'(bus.hi), 64'd0);

    do_op(1'b1, 32'd100, 32'd7, 10, -1, lat, nb, dz);
    chk("inj_lat", 64'(lat), 64'd33);
    chk("inj_lo",  64'(bus.lo), 64'd14);
    chk("inj_hi",  64'(bus.hi), 64'd2);
    chk("inj_ma",  64'(bus.mult_a), 64'd7);
    chk("inj_mb",  64'(bus.mult_b), 64'hFFFF_FFFD);

    // Issued in the same cycle as the previous done.
    do_op(1'b0, 32'd3, 32'd5, -1, -1, lat, nb, dz);
    chk("b2b_lat", 64'(lat), 64'd2);
    chk("b2b_lo",  64'(bus.lo), 64'd15);
    chk("b2b_hi",  64'(bus.hi), 64'd0);

    do_op(1'b1, 32'hFFFF_FF9C, 32'd3, -1, 15, lat, nb, dz);
    chk("rst_nodone", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = pick();
      ry = pick();
      exp_lat = (ro == 1'b0) ? 2 : ((ry == 32'd0) ? 0 : 33);
      do_op(ro, rx, ry, -1, -1, lat, nb, dz);
      chk("rand_lat", 64'(lat), 64'(exp_lat));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
